px_out_ctrl: RTL and testbench

//  Output interface stage of the convolution engine; sits downstream of the compute datapath, which is fed by inpinf.

---
 rtl/conveng_pkg.sv | 15 +
 rtl/px_out_ctrl_if.sv | 24 ++
 rtl/px_fifo.sv | 76 +++++++
 rtl/px_out_ctrl.sv | 159 +++++++++++++++
 tb/tb_px_out_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conveng_pkg.sv
// Shared types and default sizes for the convolution engine output stage.
package conveng_pkg;

  localparam int XB_DEF    = 10;
  localparam int YB_DEF    = 10;
  localparam int PB_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/px_out_ctrl_if.sv
// Pixel handshake bundle: result stream in from the datapath, pixel stream out.
// The slave modport is the output stage itself; master is the surrounding logic.
interface px_out_ctrl_if #(
  parameter int PB = 8
);
  logic [PB-1:0] res_data;
  logic          res_valid;
  logic          res_ready;
  logic [PB-1:0] px_out_data;
  logic          px_out_valid;
  logic          px_out_ready;
  logic          px_out_last_x;
  logic          px_out_last_y;

  modport slave (
    input  res_data, res_valid, px_out_ready,
    output res_ready, px_out_data, px_out_valid, px_out_last_x, px_out_last_y
  );

  modport master (
    output res_data, res_valid, px_out_ready,
    input  res_ready, px_out_data, px_out_valid, px_out_last_x, px_out_last_y
  );
endinterface

// File: rtl/px_fifo.sv
// First-word fall-through FIFO, DEPTH entries of PB bits. Head entry is always
// visible on dout; flush empties it in one cycle and has priority over push/pop.
module px_fifo #(
  parameter int DEPTH = 4,
  parameter int PB    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [PB-1:0] din,
  output logic [PB-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [PB-1:0] mem_q [DEPTH];
  logic [PB-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next pointer/occupancy/storage; pointers wrap naturally mod DEPTH.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_ok) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  // FIFO state registers; storage is cleared on reset so dout reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/px_out_ctrl.sv
// Output stage of the convolution engine: buffers results in a small FWFT FIFO,
// drives the pixel output stream and tags row/frame ends, then pulses done.
// Optional feature macro PX_OUT_STALL_CNT_EN adds the stall_cnt output.
module px_out_ctrl
  import conveng_pkg::*;
#(
  parameter int XB    = XB_DEF,
  parameter int YB    = YB_DEF,
  parameter int PB    = PB_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XB-1:0] cfg_width,
  input  logic [YB-1:0] cfg_height,
  input  logic          start,
  px_out_ctrl_if.slave  bus,
`ifdef PX_OUT_STALL_CNT_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic          done
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [XB-1:0] w_q, w_d, x_q, x_d;
  logic [YB-1:0] h_q, h_d, y_q, y_d;
  logic          res_ready_q, res_ready_d;
  logic          flush_s, push_s, pop_s;
  logic          full_s, empty_s, valid_s, last_x_s, last_y_s;
  logic [CW-1:0] count_s, count_next_s;
  logic [PB-1:0] head_s;

  assign valid_s  = !empty_s;
  assign push_s   = bus.res_valid && res_ready_q;
  assign pop_s    = valid_s && bus.px_out_ready;
  assign last_x_s = (x_q == (w_q - XB'(1)));
  assign last_y_s = (y_q == (h_q - YB'(1)));

  assign bus.res_ready     = res_ready_q;
  assign bus.px_out_valid  = valid_s;
  assign bus.px_out_data   = head_s;
  assign bus.px_out_last_x = valid_s && last_x_s;
  assign bus.px_out_last_y = valid_s && last_y_s;
  assign done              = (state_q == DONE);

  px_fifo #(.DEPTH(DEPTH), .PB(PB)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.res_data),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Frame FSM and x/y beat counters; counters only move on an output pop.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    x_d     = x_q;
    y_d     = y_q;
    flush_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          w_d = cfg_width;
          h_d = cfg_height;
          x_d = '0;
          y_d = '0;
          if ((cfg_width == '0) || (cfg_height == '0)) state_d = DONE;
          else                                         state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (pop_s) begin
          if (last_x_s) begin
            x_d = '0;
            if (last_y_s) begin
              state_d = DONE;
              flush_s = 1'b1;
            end else begin
              y_d = y_q + YB'(1);
            end
          end else begin
            x_d = x_q + XB'(1);
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is registered from the predicted next occupancy, so it never
  // depends combinationally on px_out_ready.
  always_comb begin
    if (flush_s) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_s + {{(CW-1){1'b0}}, (push_s && !full_s)}
                             - {{(CW-1){1'b0}}, pop_s};
    end
    res_ready_d = (state_d == RUN) && (count_next_s != FULL_CNT);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      res_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_ready_q <= res_ready_d;
    end
  end

`ifdef PX_OUT_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  assign stall_cnt = stall_q;

  // Saturating count of cycles holding a valid beat that is not accepted.
  always_comb begin
    if ((state_q == IDLE) && start) begin
      stall_d = '0;
    end else if (valid_s && !bus.px_out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
`endif

endmodule

// File: tb/tb_px_out_ctrl.sv
// Self-checking bench for px_out_ctrl with a queue-based reference model.
module tb_px_out_ctrl;
  import conveng_pkg::*;

  localparam int PB    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] cfg_width = '0;
  logic [9:0] cfg_height = '0;
  logic       start = 1'b0;
  logic       done;
`ifdef PX_OUT_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  px_out_ctrl_if #(.PB(PB)) bus ();

  px_out_ctrl #(.XB(10), .YB(10), .PB(PB), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .start      (start),
    .bus        (bus),
`ifdef PX_OUT_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  // Runs one frame with random handshakes; every cycle the observed outputs are
  // compared with a model holding accepted pixels in a queue.
  task automatic run_frame(input int w, input int h, input int pv, input int pr,
                           input int hold, input bit noise, output int cyc);
    logic [PB-1:0] q[$];
    int beats, popped;
    bit seen_done, exp_valid, exp_ready, do_push, do_pop, ex_lx, ex_ly;
    beats = w * h;
    popped = 0;
    seen_done = 1'b0;
    cyc = 0;
    @(negedge clk);
    cfg_width = 10'(w); cfg_height = 10'(h); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && cyc < 3000) begin
      cyc++;
      exp_valid = (q.size() > 0);
      if (popped == beats) begin
        bus.res_valid = 1'b0; bus.px_out_ready = 1'b0; start = 1'b0;
        checks++;
        if (done !== 1'b1 || bus.px_out_valid !== 1'b0 || bus.res_ready !== 1'b0) begin
          errors++;
          $display("FAIL frame_done: got done=%b valid=%b ready=%b, expected 1 0 0", done, bus.px_out_valid, bus.res_ready);
        end
        seen_done = 1'b1;
      end else begin
        exp_ready = (q.size() < DEPTH);
        checks++;
        if (done !== 1'b0 || bus.res_ready !== exp_ready || bus.px_out_valid !== exp_valid) begin
          errors++;
          $display("FAIL frame_ctrl cyc %0d: got done=%b ready=%b valid=%b, expected 0 %b %b", cyc, done, bus.res_ready, bus.px_out_valid, exp_ready, exp_valid);
        end
        if (exp_valid) begin
          ex_lx = ((popped % w) == (w - 1));
          ex_ly = ((popped / w) == (h - 1));
          checks++;
          if (bus.px_out_data !== q[0] || bus.px_out_last_x !== ex_lx || bus.px_out_last_y !== ex_ly) begin
            errors++;
            $display("FAIL beat %0d: got data=%h lx=%b ly=%b, expected %h %b %b", popped, bus.px_out_data, bus.px_out_last_x, bus.px_out_last_y, q[0], ex_lx, ex_ly);
          end
        end
        bus.res_valid    = ($urandom_range(99) < pv);
        bus.res_data     = PB'($urandom);
        bus.px_out_ready = (cyc > hold) && ($urandom_range(99) < pr);
        if (noise) begin
          start      = 1'($urandom_range(1));
          cfg_width  = 10'($urandom_range(7));
          cfg_height = 10'($urandom_range(7));
        end
        do_push = bus.res_valid && exp_ready;
        do_pop  = bus.px_out_ready && exp_valid;
        if (do_pop) begin
          void'(q.pop_front());
          popped++;
        end
        if (do_push) q.push_back(bus.res_data);
        @(negedge clk);
      end
    end
    if (!seen_done) begin
      errors++;
      $display("FAIL frame_timeout: got no done after %0d cycles, expected done", cyc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bus.res_ready !== 1'b0 || bus.px_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got done=%b ready=%b valid=%b, expected 0 0 0", done, bus.res_ready, bus.px_out_valid);
    end
  endtask

  task automatic test_reset();
    bus.res_valid = 1'b0; bus.res_data = '0; bus.px_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.res_ready !== 1'b0 || bus.px_out_valid !== 1'b0 || bus.px_out_last_x !== 1'b0 ||
        bus.px_out_last_y !== 1'b0 || done !== 1'b0 || bus.px_out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b lx=%b ly=%b done=%b data=%h, expected all 0", bus.res_ready, bus.px_out_valid, bus.px_out_last_x, bus.px_out_last_y, done, bus.px_out_data);
    end
`ifdef PX_OUT_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall: got %0d, expected 0", stall_cnt);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    run_frame(4, 2, 100, 100, 0, 1'b0, cyc);
    checks++;
    if (cyc !== 10) begin
      errors++;
      $display("FAIL basic_latency: got done at cycle %0d, expected 10", cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    run_frame(4, 2, 100, 100, 8, 1'b0, cyc);
    checks++;
    if (cyc !== 17) begin
      errors++;
      $display("FAIL backpressure_done: got done at cycle %0d, expected 17", cyc);
    end
  endtask

  task automatic test_stream();
    int cyc;
    run_frame(16, 4, 100, 100, 0, 1'b0, cyc);
    checks++;
    if (cyc !== 66) begin
      errors++;
      $display("FAIL stream_rate: got done at cycle %0d, expected 66", cyc);
    end
  endtask

  task automatic test_zero_size();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cfg_width = (k == 0) ? 10'd0 : 10'd5;
      cfg_height = (k == 0) ? 10'd3 : 10'd0;
      start = 1'b1;
      bus.res_valid = 1'b1; bus.px_out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || bus.px_out_valid !== 1'b0 || bus.res_ready !== 1'b0) begin
        errors++;
        $display("FAIL zero_done %0d: got done=%b valid=%b ready=%b, expected 1 0 0", k, done, bus.px_out_valid, bus.res_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || bus.px_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_after %0d: got done=%b valid=%b, expected 0 0", k, done, bus.px_out_valid);
      end
      bus.res_valid = 1'b0; bus.px_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    int pops, guard, cyc;
    pops = 0; guard = 0;
    @(negedge clk);
    cfg_width = 10'd4; cfg_height = 10'd2; start = 1'b1;
    bus.res_valid = 1'b1; bus.px_out_ready = 1'b1; bus.res_data = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    while (pops < 3 && guard < 50) begin
      if (bus.px_out_valid) pops++;
      guard++;
      if (pops < 3) @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.px_out_valid !== 1'b0 || bus.res_ready !== 1'b0 || bus.px_out_last_x !== 1'b0 ||
        bus.px_out_last_y !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b ready=%b lx=%b ly=%b done=%b, expected 0", bus.px_out_valid, bus.res_ready, bus.px_out_last_x, bus.px_out_last_y, done);
    end
    bus.res_valid = 1'b0; bus.px_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      checks++;
      if (done !== 1'b0 || bus.px_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_nodone %0d: got done=%b valid=%b, expected 0 0", i, done, bus.px_out_valid);
      end
    end
    run_frame(4, 2, 80, 80, 0, 1'b0, cyc);
  endtask

  task automatic test_random();
    int cyc;
    for (int f = 0; f < 8; f++) begin
      run_frame($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(30, 100),
                $urandom_range(30, 100), $urandom_range(0, 6), 1'b1, cyc);
    end
  endtask

`ifdef PX_OUT_STALL_CNT_EN
  task automatic test_stall_cnt();
    int guard;
    guard = 0;
    @(negedge clk);
    cfg_width = 10'd2; cfg_height = 10'd1; start = 1'b1;
    bus.res_valid = 1'b0; bus.px_out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; bus.res_valid = 1'b1; bus.res_data = 8'hC3;
    @(negedge clk);
    bus.res_valid = 1'b0;
    while (!bus.px_out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (stall_cnt !== 32'd5) begin
      errors++;
      $display("FAIL stall_count: got %0d, expected 5", stall_cnt);
    end
    bus.px_out_ready = 1'b1; bus.res_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.res_valid = 1'b0; bus.px_out_ready = 1'b0;
    cfg_width = 10'd0; cfg_height = 10'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stall_clear: got %0d, expected 0", stall_cnt);
    end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_zero_size();
    test_reset_mid_frame();
    test_random();
`ifdef PX_OUT_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
